// File: rtl/fir_scan_rx.sv
// Serial scan-port receiver: drives scan_en, deserialises LSB-first W-bit words
// from the FIR scan chain and queues {word, tap index} in a small output FIFO.
module fir_scan_rx #(
    parameter int unsigned TAPS  = 256,
    parameter int unsigned M     = 8,
    parameter int unsigned W     = 26,
    parameter int unsigned LAT   = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic         abort_i,
    output logic         scan_en_o,
    input  logic         scan_in_i,
    output logic [W-1:0] word_data_o,
    output logic [M-1:0] word_idx_o,
    output logic         word_valid_o,
    input  logic         word_ready_i,
    output logic         busy_o,
    output logic         done_o
);

    localparam int unsigned BCW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned LCW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_PAUSE,
        ST_DRAIN
    } state_e;

    state_e         state_q, state_d;
    logic [LCW-1:0] lead_q, lead_d;
    logic [BCW-1:0] bit_q, bit_d;
    logic [M-1:0]   idx_q, idx_d;
    logic [W-1:0]   sh_q, sh_d;
    logic           scan_en_q, scan_en_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [W-1:0]   data_mem_q [DEPTH];
    logic [M-1:0]   idx_mem_q  [DEPTH];
    logic [PW-1:0]  wr_q, rd_q;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           word_complete;
    logic           push;
    logic           pop;
    logic [W-1:0]   push_word;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // The bit sampled this cycle completes the word, so the push uses it directly.
    assign push_word     = {scan_in_i, sh_q[W-1:1]};
    assign word_complete = (state_q == ST_SHIFT) && (bit_q == BCW'(W - 1));
    assign push          = word_complete && !abort_i;
    assign pop           = (cnt_q != '0) && word_ready_i;
    assign cnt_d         = cnt_q + CW'(push) - CW'(pop);

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        lead_d  = lead_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_LEAD;
                    lead_d  = '0;
                    idx_d   = M'(TAPS - 1);
                end
            end
            ST_LEAD: begin
                if (lead_q == LCW'(LAT - 1)) begin
                    state_d = ST_SHIFT;
                    bit_d   = '0;
                end else begin
                    lead_d = lead_q + LCW'(1);
                end
            end
            ST_SHIFT: begin
                sh_d = push_word;
                if (word_complete) begin
                    bit_d = '0;
                    idx_d = idx_q - M'(1);
                    if (idx_q == '0) begin
                        state_d = ST_DRAIN;
                    end else if (cnt_d == CW'(DEPTH)) begin
                        state_d = ST_PAUSE;
                    end
                end else begin
                    bit_d = bit_q + BCW'(1);
                end
            end
            ST_PAUSE: begin
                if (cnt_q < CW'(DEPTH)) begin
                    state_d = ST_LEAD;
                    lead_d  = '0;
                end
            end
            ST_DRAIN: begin
                if (cnt_d == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort_i) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end

        scan_en_d = (state_d == ST_LEAD) || (state_d == ST_SHIFT);
        busy_d    = (state_d != ST_IDLE);
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lead_q    <= '0;
            bit_q     <= '0;
            idx_q     <= '0;
            sh_q      <= '0;
            scan_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lead_q    <= lead_d;
            bit_q     <= bit_d;
            idx_q     <= idx_d;
            sh_q      <= sh_d;
            scan_en_q <= scan_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Output FIFO; abort flushes it by clearing the pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_mem_q[i] <= '0;
                idx_mem_q[i]  <= '0;
            end
        end else if (abort_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                data_mem_q[wr_q] <= push_word;
                idx_mem_q[wr_q]  <= idx_q;
                wr_q             <= ptr_inc(wr_q);
            end
            if (pop) begin
                rd_q <= ptr_inc(rd_q);
            end
            cnt_q <= cnt_d;
        end
    end

    assign scan_en_o    = scan_en_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign word_valid_o = (cnt_q != '0);
    assign word_data_o  = data_mem_q[rd_q];
    assign word_idx_o   = idx_mem_q[rd_q];

endmodule
